genius_seq_player: RTL and testbench
====================================

// Module: genius_seq_player
// PURPOSE
//  Plays back a stored Genius color sequence by driving the 2-bit select of the
//  4:1 color mux (mux4x1 SEL_i) step by step, with timed LED-on / LED-off phases.
//  Sits between game control (which loads the sequence and starts playback) and
//  the color datapath. LED_EN_o gates the mux output. Timing advances on a
//  prescaler tick, not on raw clock edges.
// PARAMETERS
//  MAX_LEN    16  sequence RAM depth in steps (power of 2)
//  ADDR_W     4   log2(MAX_LEN)
//  ON_TICKS   4   TICK_i pulses the LED stays lit per step (>=1)
//  OFF_TICKS  2   TICK_i pulses of dark gap after each step (>=1)
//  CNT_W      8   width of tick counter; must hold max(ON_TICKS,OFF_TICKS)
// PORTS
//  CLK_i       in   1         clock, all logic on rising edge
//  RST_i       in   1         synchronous reset, active-high
//  TICK_i      in   1         single-cycle timing enable from prescaler
//  WR_EN_i     in   1         write WR_DATA_i into sequence RAM at WR_ADDR_i
//  WR_ADDR_i   in   ADDR_W    RAM write address
//  WR_DATA_i   in   2         color code 0..3 (mux select value)
//  START_i     in   1         begin playback of steps 0..LEN_i-1
//  LEN_i       in   ADDR_W+1  number of steps to play, 0..MAX_LEN
//  SEL_o       out  2         color select -> mux4x1 SEL_i
//  LED_EN_o    out  1         1 while current step is lit
//  STEP_o      out  ADDR_W    index of step being played
//  BUSY_o      out  1         1 in any state other than IDLE
//  DONE_o      out  1         one-cycle pulse when playback completes
// BEHAVIOUR
//  - Reset: state=IDLE; SEL_o=0, LED_EN_o=0, STEP_o=0, BUSY_o=0, DONE_o=0,
//    tick counter=0, latched length=0. RAM contents are NOT cleared by reset.
//  - RAM: write on clock edge when WR_EN_i, in any state; read is combinational.
//  - FSM states: IDLE, ON, OFF, FIN. All outputs are registered.
//  - IDLE: START_i=1 and LEN_i!=0 -> latch LEN_i, STEP_o=0, SEL_o=mem[0],
//    cnt=0, go ON (LED_EN_o=1 in the cycle after START_i). START_i with
//    LEN_i=0 -> go FIN directly (no LED). LEN_i>MAX_LEN is clamped to MAX_LEN.
//  - ON: LED_EN_o=1. Each TICK_i increments cnt; on the TICK_i with
//    cnt==ON_TICKS-1 -> cnt=0, LED_EN_o=0, go OFF.
//  - OFF: LED_EN_o=0, SEL_o held. On the TICK_i with cnt==OFF_TICKS-1:
//    if STEP_o==len-1 -> go FIN; else STEP_o+=1, SEL_o=mem[STEP_o+1], cnt=0, go ON.
//  - FIN: DONE_o=1 for exactly this cycle, BUSY_o=1; next cycle -> IDLE,
//    DONE_o=0, BUSY_o=0. SEL_o retains last value in IDLE.
//  - START_i outside IDLE is ignored (no restart, no queuing).
//  - Each RAM entry is sampled when its step enters ON; a write to a step not yet
//    entered is played, a write to the current or a past step is not.
//  - TICK_i and START_i in the same IDLE cycle: START handled, tick not counted.
//  - Step duration: exactly ON_TICKS ticks lit + OFF_TICKS ticks dark.
//  - Reset asserted mid-playback: next edge returns to reset values; no DONE_o.
// CONFIGURATION
//  GENIUS_SEQ_ABORT_EN defined: extra input ABORT_i (1 bit). ABORT_i=1 in ON or
//    OFF -> next edge IDLE, LED_EN_o=0, BUSY_o=0, DONE_o stays 0; ABORT_i in IDLE
//    or FIN has no effect (FIN still pulses DONE_o). ABORT_i beats TICK_i.
//  Not defined: no ABORT_i port; playback always runs to completion or reset.
// TESTING
//  1 Reset: RST_i=1 two cycles -> all outputs 0, BUSY_o=0, FSM in IDLE.
//  2 Load mem[0..2]=2,0,3; LEN_i=3, START_i pulse; TICK_i every 4 clocks ->
//    SEL_o 2,0,3, each lit 4 ticks / dark 2 ticks; DONE_o one pulse after
//    18 ticks; BUSY_o drops the cycle after.
//  3 START_i with LEN_i=0 -> DONE_o pulses 1 cycle later, LED_EN_o never 1.
//  4 During step 0 of LEN=3 playback, write mem[1]=1 and pulse START_i ->
//    step 1 plays SEL_o=1; START ignored, STEP_o continues 0,1,2.
//  5 LEN_i=16 with all steps written -> STEP_o wraps 0..15 without overflow,
//    one DONE_o; RST_i at step 7 -> IDLE next edge, no DONE_o.
//  6 (GENIUS_SEQ_ABORT_EN) ABORT_i same cycle as TICK_i in OFF -> IDLE next
//    cycle, DONE_o=0, STEP_o unchanged from abort cycle.

Source files
------------

// File: rtl/genius_seq_player.sv
// genius_seq_player: steps a stored color sequence onto the mux select with timed LED on/off phases.
// Optional ABORT_i input when GENIUS_SEQ_ABORT_EN is defined.
module genius_seq_player #(
  parameter int MAX_LEN   = 16,
  parameter int ADDR_W    = 4,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2,
  parameter int CNT_W     = 8
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  input  logic              TICK_i,
  input  logic              WR_EN_i,
  input  logic [ADDR_W-1:0] WR_ADDR_i,
  input  logic [1:0]        WR_DATA_i,
  input  logic              START_i,
  input  logic [ADDR_W:0]   LEN_i,
  output logic [1:0]        SEL_o,
  output logic              LED_EN_o,
  output logic [ADDR_W-1:0] STEP_o,
  output logic              BUSY_o,
  output logic              DONE_o
`ifdef GENIUS_SEQ_ABORT_EN
  , input logic             ABORT_i
`endif
);
  typedef enum logic [1:0] {IDLE, ON, OFF, FIN} state_t;
  state_t            state;
  logic [1:0]        mem [MAX_LEN];
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] nxt_step;
  logic              abort;
`ifdef GENIUS_SEQ_ABORT_EN
  assign abort = ABORT_i;
`else
  assign abort = 1'b0;
`endif
  assign nxt_step = (state == IDLE) ? '0 : STEP_o + 1'b1;
  always_ff @(posedge CLK_i)
    if (WR_EN_i) mem[WR_ADDR_i] <= WR_DATA_i;
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state    <= IDLE;
      SEL_o    <= '0;
      LED_EN_o <= 1'b0;
      STEP_o   <= '0;
      BUSY_o   <= 1'b0;
      DONE_o   <= 1'b0;
      cnt      <= '0;
      len      <= '0;
    end else begin
      case (state)
        IDLE: if (START_i) begin
          BUSY_o <= 1'b1;
          if (LEN_i == '0) begin
            state  <= FIN;
            DONE_o <= 1'b1;
          end else begin
            state    <= ON;
            len      <= (LEN_i > (ADDR_W+1)'(MAX_LEN)) ? (ADDR_W+1)'(MAX_LEN) : LEN_i;
            STEP_o   <= nxt_step;
            SEL_o    <= mem[nxt_step];
            cnt      <= '0;
            LED_EN_o <= 1'b1;
          end
        end
        ON: if (abort) begin
          state    <= IDLE;
          LED_EN_o <= 1'b0;
          BUSY_o   <= 1'b0;
          cnt      <= '0;
        end else if (TICK_i) begin
          cnt <= (cnt == CNT_W'(ON_TICKS-1)) ? '0 : cnt + 1'b1;
          if (cnt == CNT_W'(ON_TICKS-1)) begin
            state    <= OFF;
            LED_EN_o <= 1'b0;
          end
        end
        OFF: if (abort) begin
          state  <= IDLE;
          BUSY_o <= 1'b0;
          cnt    <= '0;
        end else if (TICK_i) begin
          cnt <= (cnt == CNT_W'(OFF_TICKS-1)) ? '0 : cnt + 1'b1;
          if (cnt == CNT_W'(OFF_TICKS-1)) begin
            if ({1'b0, STEP_o} == len - 1'b1) begin
              state  <= FIN;
              DONE_o <= 1'b1;
            end else begin
              state    <= ON;
              STEP_o   <= nxt_step;
              SEL_o    <= mem[nxt_step];
              LED_EN_o <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          DONE_o <= 1'b0;
          BUSY_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_genius_seq_player.sv
// tb_genius_seq_player: randomized and directed playback checked every cycle against a tick-count model.
module tb_genius_seq_player;
  localparam int ON_T = 4, OFF_T = 2, PER = ON_T + OFF_T, ML = 16;
  logic CLK_i = 1'b0, RST_i, TICK_i, WR_EN_i, START_i;
  logic [3:0] WR_ADDR_i;
  logic [1:0] WR_DATA_i;
  logic [4:0] LEN_i;
  logic [1:0] SEL_o;
  logic LED_EN_o, BUSY_o, DONE_o;
  logic [3:0] STEP_o;
  logic ab;
`ifdef GENIUS_SEQ_ABORT_EN
  logic ABORT_i;
  assign ABORT_i = ab;
`endif
  genius_seq_player dut (
    .CLK_i(CLK_i), .RST_i(RST_i), .TICK_i(TICK_i), .WR_EN_i(WR_EN_i),
    .WR_ADDR_i(WR_ADDR_i), .WR_DATA_i(WR_DATA_i), .START_i(START_i), .LEN_i(LEN_i),
    .SEL_o(SEL_o), .LED_EN_o(LED_EN_o), .STEP_o(STEP_o), .BUSY_o(BUSY_o), .DONE_o(DONE_o)
`ifdef GENIUS_SEQ_ABORT_EN
    , .ABORT_i(ABORT_i)
`endif
  );
  always #5 CLK_i = ~CLK_i;
  // Model: playback position is just the number of ticks seen since start.
  logic [1:0] mm [ML];
  bit m_play, m_fin;
  int m_n, m_len, vec, errs;
  logic [1:0] m_sel;
  logic [3:0] m_step;
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    vec++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, o, e, $time);
    end
  endtask
  task automatic cyc(input bit rst, input bit tick, input bit start, input logic [4:0] len,
                     input bit we, input logic [3:0] wa, input logic [1:0] wd, input bit abt);
    RST_i = rst; TICK_i = tick; START_i = start; LEN_i = len;
    WR_EN_i = we; WR_ADDR_i = wa; WR_DATA_i = wd; ab = abt;
    @(posedge CLK_i);
    if (rst) begin
      m_play = 0; m_fin = 0; m_n = 0; m_len = 0; m_sel = 0; m_step = 0;
    end else if (m_fin) m_fin = 0;
    else if (m_play) begin
      if (abt) m_play = 0;
      else if (tick) begin
        m_n++;
        if (m_n == m_len * PER) begin m_play = 0; m_fin = 1; end
        else begin
          m_step = 4'(m_n / PER);
          if (m_n % PER == 0) m_sel = mm[m_step];
        end
      end
    end else if (start) begin
      if (len == 0) m_fin = 1;
      else begin
        m_len = (len > ML) ? ML : int'(len);
        m_n = 0; m_step = 0; m_sel = mm[0]; m_play = 1;
      end
    end
    if (we) mm[wa] = wd;
    #1;
    chk("busy", 8'(BUSY_o), 8'(m_play | m_fin));
    chk("done", 8'(DONE_o), 8'(m_fin));
    chk("led", 8'(LED_EN_o), 8'(m_play && (m_n % PER) < ON_T));
    chk("step", 8'(STEP_o), 8'(m_step));
    chk("sel", 8'(SEL_o), 8'(m_sel));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic run(input int period, input bit rnd, input int budget);
    int c = 0;
    while ((m_play || m_fin) && c < budget) begin
      if (rnd) cyc(0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, 5'($urandom_range(0, 20)),
                   $urandom_range(0, 3) == 0, 4'($urandom), 2'($urandom), 0);
      else cyc(0, c % period == period - 1, 0, 0, 0, 0, 0, 0);
      c++;
    end
    vec++;
    assert (!(m_play || m_fin)) else begin
      errs++;
      $error("FAIL timeout: observed busy after %0d cycles expected idle", c);
    end
  endtask
  initial begin
    vec = 0; errs = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < ML; i++) cyc(0, 0, 0, 0, 1, 4'(i), 2'($urandom), 0);
    // Basic three-step playback with a tick every 4 clocks.
    cyc(0, 0, 0, 0, 1, 0, 2, 0);
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 2, 3, 0);
    cyc(0, 0, 1, 3, 0, 0, 0, 0);
    run(4, 0, 200);
    idle(2);
    // Zero length: straight to done, no LED.
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    idle(3);
    // Write to an upcoming step plus an ignored restart during step 0.
    cyc(0, 1, 1, 3, 0, 0, 0, 0);
    cyc(0, 0, 1, 5, 1, 1, 1, 0);
    cyc(0, 1, 0, 0, 1, 0, 3, 0);
    run(2, 0, 200);
    // Full length, then clamped length with reset at step 7.
    for (int i = 0; i < ML; i++) cyc(0, 0, 0, 0, 1, 4'(i), 2'($urandom), 0);
    cyc(0, 0, 1, 16, 0, 0, 0, 0);
    run(1, 0, 400);
    cyc(0, 0, 1, 20, 0, 0, 0, 0);
    for (int c = 0; m_step != 7 && c < 200; c++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
`ifdef GENIUS_SEQ_ABORT_EN
    cyc(0, 0, 1, 4, 0, 0, 0, 0);
    for (int c = 0; (m_n % PER) < ON_T && c < 50; c++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    idle(2);
`endif
    for (int k = 0; k < 12; k++) begin
      cyc(0, $urandom_range(0, 1) == 1, 1, 5'($urandom_range(0, 20)), 0, 0, 0, 0);
      run(1, 1, 3000);
      idle(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
